// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder: masked write / raw read after WAIT_CYCLES wait states
// Optional range check compiled in with `define DM_RANGE_CHECK_EN.
module dm_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  byteEn,
    input  logic [31:0] wd,
    output logic        ack,
    output logic [31:0] rd,
    output logic        busy,
    output logic        err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT state, nextState;

    logic [31:0]           mem [DEPTH] = '{default: '0};
    logic [3:0]            cnt;
    logic                  heldWe;
    logic [ADDR_WIDTH-1:0] heldIdx;
    logic [3:0]            heldBe;
    logic [31:0]           heldWd;
    logic                  heldOor;

    logic                  reqOor;
    logic                  accWe;
    logic [ADDR_WIDTH-1:0] accIdx;
    logic [3:0]            accBe;
    logic [31:0]           accWd;
    logic                  accOor;
    logic                  doAccess;
    logic [31:0]           curWord;
    logic [31:0]           merged;
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^{addr[1:0], addr[31:ADDR_WIDTH+2]};

`ifdef DM_RANGE_CHECK_EN
    assign reqOor = (addr[31:ADDR_WIDTH+2] != '0);
`else
    assign reqOor = 1'b0;
`endif

    // With zero wait states the access happens on the capture edge, so use the live inputs.
    always_comb begin
        if (state == IDLE) begin
            accWe  = we;
            accIdx = addr[ADDR_WIDTH+1:2];
            accBe  = byteEn;
            accWd  = wd;
            accOor = reqOor;
        end else begin
            accWe  = heldWe;
            accIdx = heldIdx;
            accBe  = heldBe;
            accWd  = heldWd;
            accOor = heldOor;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (req) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign doAccess = (nextState == RESP) && (state != RESP);
    assign curWord  = mem[accIdx];

    always_comb begin
        merged = curWord;
        for (int i = 0; i < 4; i++) begin
            if (accBe[i]) merged[8*i +: 8] = accWd[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            heldWe  <= 1'b0;
            heldIdx <= '0;
            heldBe  <= 4'd0;
            heldWd  <= 32'd0;
            heldOor <= 1'b0;
            ack     <= 1'b0;
            rd      <= 32'd0;
            err     <= 1'b0;
        end else begin
            state <= nextState;
            ack   <= doAccess;
            err   <= doAccess && accOor;
            if (state == IDLE && req) begin
                heldWe  <= we;
                heldIdx <= addr[ADDR_WIDTH+1:2];
                heldBe  <= byteEn;
                heldWd  <= wd;
                heldOor <= reqOor;
                cnt     <= 4'(WAIT_CYCLES);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (doAccess) begin
                if (accOor)     rd <= 32'd0;
                else if (accWe) rd <= merged;
                else            rd <= curWord;
            end
        end
    end

    // Memory has no reset; gating on reset keeps a reset-time edge from writing.
    always_ff @(posedge clk) begin
        if (reset && doAccess && accWe && !accOor) begin
            mem[accIdx] <= merged;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - vector table + scoreboard bench for dm_responder
module tb_dm_responder;

    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteEn;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        busy;
    logic        err;

    dm_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .byteEn(byteEn), .wd(wd), .ack(ack), .rd(rd), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } expT;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] expRd;
        logic        expErr;
    } vecT;

    expT expQ[$];
    vecT vecs[$];
    int  nCompared   = 0;
    int  nMismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic waitAck(input string name);
        int  n;
        int  busyLow;
        int  extraAcks;
        bit  seen;
        expT e;
        n = 0; busyLow = 0; seen = 0; extraAcks = 0;
        e.rd = 32'hx; e.err = 1'bx;
        if (expQ.size() > 0) e = expQ.pop_front();
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (ack) begin
                seen = 1;
            end else begin
                if (!busy) busyLow++;
                req    = 1'($urandom_range(0, 1));
                we     = 1'($urandom_range(0, 1));
                addr   = $urandom;
                wd     = $urandom;
                byteEn = 4'($urandom);
            end
        end
        if (!seen) begin
            nCompared++;
            nMismatched++;
            $display("FAIL %s_timeout: no ack within %0d cycles, expected ack", name, n);
            req = 1'b0;
            return;
        end
        check({name, "_latency"}, 32'(n), 32'(WAIT_CYCLES + 1));
        check({name, "_busy_wait"}, 32'(busyLow), 32'd0);
        check({name, "_rd"}, rd, e.rd);
        check({name, "_err"}, {31'd0, err}, {31'd0, e.err});
        req = 1'b1;
        we  = 1'b0;
        @(negedge clk);
        check({name, "_ack_width"}, {31'd0, ack}, 32'd0);
        check({name, "_rd_hold"}, rd, e.rd);
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack) extraAcks++;
        end
        check({name, "_no_extra_ack"}, 32'(extraAcks), 32'd0);
    endtask

    task automatic doAccess(input string name, input vecT v);
        expT e;
        @(negedge clk);
        req = 1'b1; we = v.w; addr = v.a; byteEn = v.be; wd = v.d;
        e.rd = v.expRd; e.err = v.expErr;
        expQ.push_back(e);
        waitAck(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        expT e;
        vecT v;
        int  acksInReset;

        vecs.push_back('{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 4'b0100, 32'h00AA_0000, 32'hDEAA_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 32'hDEAA_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, 32'hDEAA_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0013, 4'b0000, 32'h0000_0000, 32'hDEAA_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0014, 4'b0011, 32'h1234_5678, 32'h0000_5678, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0014, 4'b1000, 32'hAB00_0000, 32'hAB00_5678, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0016, 4'b0000, 32'h0000_0000, 32'hAB00_5678, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_3FFC, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_3FFC, 4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0});
`ifdef DM_RANGE_CHECK_EN
        vecs.push_back('{1'b1, 32'h0000_4000, 4'b1111, 32'h1111_1111, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0});
`else
        vecs.push_back('{1'b1, 32'h0000_4000, 4'b1111, 32'h1111_1111, 32'h1111_1111, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h1111_1111, 1'b0});
`endif

        reset = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0; byteEn = 4'h0; wd = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rd", rd, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);

        reset = 1'b1;
        e.rd = 32'h0; e.err = 1'b0;
        expQ.push_back(e);
        waitAck("release_read0");

        for (int i = 0; i < vecs.size(); i++) begin
            doAccess($sformatf("vec%0d", i), vecs[i]);
        end

        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; byteEn = 4'hF; wd = 32'h1234_5678;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        acksInReset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) acksInReset++;
        end
        check("midreset_no_ack", 32'(acksInReset), 32'd0);
        reset = 1'b1;
        v = '{1'b0, 32'h0000_0020, 4'b0000, 32'h0, 32'h0000_0000, 1'b0};
        doAccess("midreset_read20", v);

        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
